regfile_mp_sb: RTL and testbench

- Parametrised multi-port register file for the dual-core datapath.
- Provides NRD combinational read ports and NWR synchronous write ports; one write port per core writeback.
- Register 0 is hardwired to zero.
- An integrated scoreboard holds one busy bit per register, so issue logic can detect pending writes without external tracking.

---
 rtl/regfile_mp_sb.sv | 98 +++++++++
 tb/tb_regfile_mp_sb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with an integrated per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy-clear to the read ports.
module regfile_mp_sb #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int NRD     = 2,
  parameter int NWR     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NRD*REGBITS-1:0] ra,
  output logic [NRD*WIDTH-1:0]   rd,
  output logic [NRD-1:0]         rbusy,
  input  logic [NWR-1:0]         we,
  input  logic [NWR*REGBITS-1:0] wa,
  input  logic [NWR*WIDTH-1:0]   wd,
  input  logic                   sb_set,
  input  logic [REGBITS-1:0]     sb_addr,
  input  logic                   sb_flush,
  output logic [REGBITS:0]       busy_cnt
);

  localparam int NREG = 2**REGBITS;

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  logic [REGBITS:0] cnt_nxt;

  // Later ports are assigned last, so the highest-index port wins a same-address conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (wa[j*REGBITS +: REGBITS] != '0))
          regs[wa[j*REGBITS +: REGBITS]] <= wd[j*WIDTH +: WIDTH];
      end
    end
  end

  // Applied lowest priority first: writeback clear, then issue set, then flush.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) busy_nxt[wa[j*REGBITS +: REGBITS]] = 1'b0;
    end
    if (sb_set) busy_nxt[sb_addr] = 1'b1;
    if (sb_flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREG; r++)
      cnt_nxt = cnt_nxt + {{REGBITS{1'b0}}, busy_nxt[r]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [REGBITS-1:0] addr;
    logic [WIDTH-1:0]   val;
    logic               bsy;

    assign addr = ra[i*REGBITS +: REGBITS];

    always_comb begin
      val = regs[addr];
      bsy = busy[addr];
`ifdef REGFILE_BYPASS_EN
      // A pending write completes this edge; only a new producer issued now keeps it busy.
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (wa[j*REGBITS +: REGBITS] == addr)) begin
          val = wd[j*WIDTH +: WIDTH];
          bsy = sb_set && (sb_addr == addr);
        end
      end
`endif
      if (addr == '0) begin
        val = '0;
        bsy = 1'b0;
      end
    end

    assign rd[i*WIDTH +: WIDTH] = val;
    assign rbusy[i]             = bsy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed vector table, hand-written
// reset/bypass sequences, and randomized traffic against a behavioural model.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  ra;
  logic [15:0] rd;
  logic [1:0]  rbusy;
  logic [1:0]  we;
  logic [5:0]  wa;
  logic [15:0] wd;
  logic        sb_set;
  logic [2:0]  sb_addr;
  logic        sb_flush;
  logic [3:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] mregs [8];
  bit         mbusy [8];

  regfile_mp_sb #(.WIDTH(8), .REGBITS(3), .NRD(2), .NWR(2)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr),
    .sb_flush(sb_flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] we;
    logic [2:0] wa0, wa1;
    logic [7:0] wd0, wd1;
    logic       sbs;
    logic [2:0] sba;
    logic       fl;
    logic [2:0] ra0, ra1;
    logic [7:0] erd0, erd1;
    logic       erb0, erb1;
    logic [3:0] ecnt;
  } vec_t;

  vec_t tbl [10];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] w, input logic [2:0] a0, input logic [2:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1, input logic s,
                               input logic [2:0] sa, input logic f, input logic [2:0] r0,
                               input logic [2:0] r1);
    we = w; wa = {a1, a0}; wd = {d1, d0};
    sb_set = s; sb_addr = sa; sb_flush = f;
    ra = {r1, r0};
  endtask

  task automatic idleInputs();
    we = 2'b00; sb_set = 1'b0; sb_flush = 1'b0;
  endtask

  task automatic modelReset();
    for (int r = 0; r < 8; r++) begin
      mregs[r] = 8'h00;
      mbusy[r] = 1'b0;
    end
  endtask

  // Behavioural view of one clock edge using the inputs currently driven.
  task automatic modelEdge();
    bit nb [8];
    for (int r = 0; r < 8; r++) nb[r] = mbusy[r];
    for (int j = 0; j < 2; j++) begin
      int a = int'(wa[j*3 +: 3]);
      if (we[j] && a != 0) begin
        mregs[a] = wd[j*8 +: 8];
        nb[a] = 1'b0;
      end
    end
    if (sb_set && sb_addr != 3'd0) nb[sb_addr] = 1'b1;
    if (sb_flush) for (int r = 0; r < 8; r++) nb[r] = 1'b0;
    for (int r = 0; r < 8; r++) mbusy[r] = nb[r];
  endtask

  function automatic int modelCount();
    int c = 0;
    for (int r = 0; r < 8; r++) c += int'(mbusy[r]);
    return c;
  endfunction

  task automatic checkOutput(input string tag);
    for (int i = 0; i < 2; i++) begin
      int a = int'(ra[i*3 +: 3]);
      logic [7:0] ev = mregs[a];
      logic       eb = mbusy[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < 2; j++) begin
        if (we[j] && int'(wa[j*3 +: 3]) == a) begin
          ev = wd[j*8 +: 8];
          eb = sb_set && int'(sb_addr) == a;
        end
      end
`endif
      if (a == 0) begin
        ev = 8'h00;
        eb = 1'b0;
      end
      compare($sformatf("%s rd%0d", tag, i), 32'(rd[i*8 +: 8]), 32'(ev));
      compare($sformatf("%s rbusy%0d", tag, i), 32'(rbusy[i]), 32'(eb));
    end
    compare($sformatf("%s busy_cnt", tag), 32'(busy_cnt), 32'(modelCount()));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, time %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{2'b11, 3'd3, 3'd5, 8'hA5, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd3, 3'd5, 8'hA5, 8'h3C, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{2'b01, 3'd0, 3'd0, 8'hFF, 8'h00, 1'b1, 3'd0, 1'b0, 3'd0, 3'd3, 8'h00, 8'hA5, 1'b0, 1'b0, 4'd0};
    tbl[2] = '{2'b11, 3'd2, 3'd2, 8'h11, 8'h22, 1'b0, 3'd0, 1'b0, 3'd2, 3'd0, 8'h22, 8'h00, 1'b0, 1'b0, 4'd0};
    tbl[3] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd4, 1'b0, 3'd4, 3'd2, 8'h00, 8'h22, 1'b1, 1'b0, 4'd1};
    tbl[4] = '{2'b10, 3'd0, 3'd4, 8'h00, 8'h77, 1'b1, 3'd4, 1'b0, 3'd4, 3'd0, 8'h77, 8'h00, 1'b1, 1'b0, 4'd1};
    tbl[5] = '{2'b01, 3'd4, 3'd0, 8'h88, 8'h00, 1'b0, 3'd0, 1'b0, 3'd4, 3'd0, 8'h88, 8'h00, 1'b0, 1'b0, 4'd0};
    tbl[6] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd1, 1'b0, 3'd1, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 4'd1};
    tbl[7] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd2, 1'b0, 3'd1, 3'd2, 8'h00, 8'h22, 1'b1, 1'b1, 4'd2};
    tbl[8] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd6, 1'b0, 3'd6, 3'd2, 8'h00, 8'h22, 1'b1, 1'b1, 4'd3};
    tbl[9] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd7, 1'b1, 3'd7, 3'd6, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0};

    rst_n = 1'b0;
    applyStimulus(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 3'd3, 3'd5);
    modelReset();
    #3;
    compare("reset rd", 32'(rd), 32'h0);
    compare("reset rbusy", 32'(rbusy), 32'h0);
    compare("reset busy_cnt", 32'(busy_cnt), 32'h0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table: each row is applied for one edge, then reads are checked with writes idle.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(tbl[k].we, tbl[k].wa0, tbl[k].wa1, tbl[k].wd0, tbl[k].wd1,
                    tbl[k].sbs, tbl[k].sba, tbl[k].fl, tbl[k].ra0, tbl[k].ra1);
      @(posedge clk); #1;
      idleInputs();
      #1;
      compare($sformatf("vec%0d rd0", k), 32'(rd[7:0]), 32'(tbl[k].erd0));
      compare($sformatf("vec%0d rd1", k), 32'(rd[15:8]), 32'(tbl[k].erd1));
      compare($sformatf("vec%0d rbusy0", k), 32'(rbusy[0]), 32'(tbl[k].erb0));
      compare($sformatf("vec%0d rbusy1", k), 32'(rbusy[1]), 32'(tbl[k].erb1));
      compare($sformatf("vec%0d busy_cnt", k), 32'(busy_cnt), 32'(tbl[k].ecnt));
    end

    // Asynchronous reset while writes are being driven: contents vanish with no clock edge.
    applyStimulus(2'b11, 3'd3, 3'd5, 8'h99, 8'h66, 1'b1, 3'd3, 1'b0, 3'd3, 3'd4);
    #1 rst_n = 1'b0;
    #1;
    compare("async reset rd0", 32'(rd[7:0]), 32'h0);
    compare("async reset rd1", 32'(rd[15:8]), 32'h0);
    compare("async reset busy_cnt", 32'(busy_cnt), 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idleInputs();
    #1;
    compare("post reset rd0", 32'(rd[7:0]), 32'h0);
    compare("post reset rbusy0", 32'(rbusy[0]), 32'h0);
    modelReset();
    @(posedge clk); #1;

    // Same-cycle write to a busy register that is being read.
    applyStimulus(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd6, 1'b0, 3'd6, 3'd0);
    @(posedge clk); #1;
    applyStimulus(2'b01, 3'd6, 3'd0, 8'h5A, 8'h00, 1'b0, 3'd0, 1'b0, 3'd6, 3'd0);
    #2;
`ifdef REGFILE_BYPASS_EN
    compare("bypass rd0", 32'(rd[7:0]), 32'h5A);
    compare("bypass rbusy0", 32'(rbusy[0]), 32'h0);
`else
    compare("nobypass rd0", 32'(rd[7:0]), 32'h00);
    compare("nobypass rbusy0", 32'(rbusy[0]), 32'h1);
`endif
    compare("pre-write busy_cnt", 32'(busy_cnt), 32'h1);
    @(posedge clk); #1;
    idleInputs();
    #1;
    compare("after write rd0", 32'(rd[7:0]), 32'h5A);
    compare("after write rbusy0", 32'(rbusy[0]), 32'h0);
    compare("after write busy_cnt", 32'(busy_cnt), 32'h0);

    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    modelReset();
    @(posedge clk); #1;

    // Randomized traffic against the behavioural model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(2'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 3'($urandom), ($urandom_range(0, 15) == 0),
                    3'($urandom), 3'($urandom));
      #3;
      checkOutput($sformatf("rand%0d", n));
      @(posedge clk);
      modelEdge();
      #1;
    end
    idleInputs();
    #2;
    checkOutput("rand final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
